// File: rtl/overload_feedback_monitor.sv
// Motor protection monitor: debounced phase-current overload detector and
// hall-sensor loss-of-feedback watchdog, both feeding the fault detector.
module overload_feedback_monitor #(
  parameter int CUR_W      = 12,
  parameter int OVL_COUNT  = 4,
  parameter int FB_TIMEOUT = 50000,
  parameter int TMR_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             motor_en,
  input  logic [CUR_W-1:0] cur_sample,
  input  logic             cur_valid,
  input  logic [CUR_W-1:0] cur_limit,
  input  logic [2:0]       hall,
  output logic             current_overload,
  output logic             no_feedback,
  output logic             hall_edge
);

  localparam int CNT_W = $clog2(OVL_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVL_COUNT - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(FB_TIMEOUT - 1);

  typedef enum logic {
    OVL_OK,
    OVL_TRIP
  } ovl_state_t;

  typedef enum logic [1:0] {
    FB_IDLE,
    FB_WATCH,
    FB_LOST
  } fb_state_t;

  // ---------------------------------------------------------------------------
  // Hall input synchronizer and edge detector
  // ---------------------------------------------------------------------------
  logic [2:0] hall_meta;
  logic [2:0] hall_sync;
  logic [2:0] hall_prev;
  logic       hall_bad;
  logic       hall_bad_d;

  // 000 and 111 can never be produced by a healthy three-sensor hall array.
  assign hall_bad = (hall_sync == 3'b000) || (hall_sync == 3'b111);

  // NOTE: sequential state is written with <= only, so every flop samples the
  // pre-edge value of its neighbours and the pipeline order is independent of
  // statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      hall_meta  <= 3'b000;
      hall_sync  <= 3'b000;
      hall_prev  <= 3'b000;
      hall_edge  <= 1'b0;
      hall_bad_d <= 1'b0;
    end else begin
      hall_meta  <= hall;
      hall_sync  <= hall_meta;
      hall_prev  <= hall_sync;
      hall_edge  <= (hall_sync != hall_prev) && !hall_bad;
      hall_bad_d <= hall_bad;
    end
  end

  // ---------------------------------------------------------------------------
  // Overcurrent debounce FSM
  // ---------------------------------------------------------------------------
  ovl_state_t       ovl_state;
  ovl_state_t       ovl_next;
  logic [CNT_W-1:0] ovl_cnt;
  logic [CNT_W-1:0] ovl_cnt_next;
  logic             over_limit;
  logic             run_sample;

  assign over_limit = cur_sample > cur_limit;

  // NOTE: every variable gets its default before any branch, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    ovl_next     = ovl_state;
    ovl_cnt_next = ovl_cnt;
    // A "run" sample is one that pushes toward the opposite state.
    run_sample   = (ovl_state == OVL_OK) ? over_limit : !over_limit;
    if (cur_valid) begin
      if (run_sample) begin
        if (ovl_cnt >= CNT_LAST) begin
          ovl_next     = (ovl_state == OVL_OK) ? OVL_TRIP : OVL_OK;
          ovl_cnt_next = '0;
        end else begin
          ovl_cnt_next = ovl_cnt + CNT_W'(1);
        end
      end else begin
        ovl_cnt_next = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovl_state        <= OVL_OK;
      ovl_cnt          <= '0;
      current_overload <= 1'b0;
    end else begin
      ovl_state        <= ovl_next;
      ovl_cnt          <= ovl_cnt_next;
      current_overload <= (ovl_next == OVL_TRIP);
    end
  end

  // ---------------------------------------------------------------------------
  // Loss-of-feedback watchdog FSM
  // ---------------------------------------------------------------------------
  fb_state_t        fb_state;
  fb_state_t        fb_next;
  logic [TMR_W-1:0] fb_tmr;
  logic [TMR_W-1:0] fb_tmr_next;

  always_comb begin
    fb_next     = fb_state;
    fb_tmr_next = fb_tmr;
    unique case (fb_state)
      FB_IDLE: begin
        fb_tmr_next = '0;
        if (motor_en) fb_next = FB_WATCH;
      end
      FB_WATCH: begin
        if (!motor_en) begin
          fb_next     = FB_IDLE;
          fb_tmr_next = '0;
        end else if (hall_edge) begin
          fb_tmr_next = '0;
        end else if ((fb_tmr == TMR_LAST) || (hall_bad && hall_bad_d)) begin
          fb_next = FB_LOST;
        end else begin
          fb_tmr_next = fb_tmr + TMR_W'(1);
        end
      end
      FB_LOST: begin
        // Sticky until the drive is disabled; the timer is frozen for debug.
        if (!motor_en) begin
          fb_next     = FB_IDLE;
          fb_tmr_next = '0;
        end
      end
      default: begin
        fb_next     = FB_IDLE;
        fb_tmr_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fb_state    <= FB_IDLE;
      fb_tmr      <= '0;
      no_feedback <= 1'b0;
    end else begin
      fb_state    <= fb_next;
      fb_tmr      <= fb_tmr_next;
      no_feedback <= (fb_state == FB_LOST);
    end
  end

endmodule

// File: tb/tb_overload_feedback_monitor.sv
// Directed bench for overload_feedback_monitor: expected values are queued
// when stimulus is driven and popped when the DUT output is sampled.
module tb_overload_feedback_monitor;

  localparam int CUR_W      = 12;
  localparam int OVL_COUNT  = 4;
  localparam int FB_TIMEOUT = 100;
  localparam int TMR_W      = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             motor_en;
  logic [CUR_W-1:0] cur_sample;
  logic             cur_valid;
  logic [CUR_W-1:0] cur_limit;
  logic [2:0]       hall;
  logic             current_overload;
  logic             no_feedback;
  logic             hall_edge;

  overload_feedback_monitor #(
    .CUR_W      (CUR_W),
    .OVL_COUNT  (OVL_COUNT),
    .FB_TIMEOUT (FB_TIMEOUT),
    .TMR_W      (TMR_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .motor_en         (motor_en),
    .cur_sample       (cur_sample),
    .cur_valid        (cur_valid),
    .cur_limit        (cur_limit),
    .hall             (hall),
    .current_overload (current_overload),
    .no_feedback      (no_feedback),
    .hall_edge        (hall_edge)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty observed %0d expected none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed %0d expected %0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic send(input int v, input logic exp, input string tag, input int gap);
    cur_sample = CUR_W'(v);
    cur_valid  = 1'b1;
    push(tag, {31'd0, exp});
    tick();
    cur_valid = 1'b0;
    check({31'd0, current_overload});
    repeat (gap) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed running expected finished");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    motor_en   = 1'b0;
    cur_sample = '0;
    cur_valid  = 1'b0;
    cur_limit  = 12'd1000;
    hall       = 3'b001;
    tick();
    tick();
    push("rst_overload", 0);   check({31'd0, current_overload});
    push("rst_no_feedback", 0); check({31'd0, no_feedback});
    push("rst_hall_edge", 0);  check({31'd0, hall_edge});
    push("rst_ovl_cnt", 0);    check(32'(dut.ovl_cnt));
    push("rst_fb_tmr", 0);     check(32'(dut.fb_tmr));
    rst = 1'b0;
    repeat (5) tick();

    // Broken run: three over, one exactly at the limit, one over.
    send(1001, 0, "run3_a", 0);
    send(1001, 0, "run3_b", 0);
    send(1001, 0, "run3_c", 0);
    send(1000, 0, "run3_eq", 0);
    send(1001, 0, "run3_after", 0);
    send(900,  0, "clear", 0);
    // Four consecutive over-limit samples trip on the fourth.
    send(1001, 0, "trip_1", 0);
    send(1001, 0, "trip_2", 0);
    send(1001, 0, "trip_3", 0);
    send(1001, 1, "trip_4", 0);
    // Release with 10-cycle gaps; a single over-limit sample restarts the run.
    send(900,  1, "rel_a1", 10);
    send(900,  1, "rel_a2", 10);
    send(900,  1, "rel_a3", 10);
    send(1200, 1, "rel_over", 10);
    send(900,  1, "rel_b1", 10);
    send(900,  1, "rel_b2", 10);
    send(1000, 1, "rel_b3_eq", 10);
    send(900,  0, "rel_b4", 10);

    // Hall edge latency, checked while the watchdog is idle.
    hall = 3'b011;
    for (int i = 1; i <= 4; i++) begin
      tick();
      push("edge_latency", (i == 3) ? 1 : 0);
      check({31'd0, hall_edge});
    end
    hall = 3'b001;
    repeat (5) tick();

    // Healthy rotation: an edge every 50 cycles keeps feedback alive.
    motor_en = 1'b1;
    tick();
    for (int s = 0; s < 3; s++) begin
      hall = (s == 0) ? 3'b011 : (s == 1) ? 3'b010 : 3'b001;
      for (int i = 1; i <= 50; i++) begin
        tick();
        push("rot_edge", (i == 3) ? 1 : 0);
        check({31'd0, hall_edge});
        push("rot_no_feedback", 0);
        check({31'd0, no_feedback});
      end
    end

    // Frozen hall: timeout then release by motor_en.
    motor_en = 1'b0;
    tick();
    tick();
    hall = 3'b101;
    repeat (5) tick();
    motor_en = 1'b1;
    for (int k = 1; k <= 102; k++) begin
      tick();
      if (k == 101) begin push("timeout_before", 0); check({31'd0, no_feedback}); end
      if (k == 102) begin push("timeout_at", 1);     check({31'd0, no_feedback}); end
    end
    motor_en = 1'b0;
    tick();
    push("lost_hold_one", 1); check({31'd0, no_feedback});
    tick();
    push("lost_cleared", 0);  check({31'd0, no_feedback});

    // Invalid code 111 forces loss of feedback quickly.
    hall = 3'b001;
    repeat (5) tick();
    motor_en = 1'b1;
    repeat (3) tick();
    hall = 3'b111;
    for (int k = 1; k <= 5; k++) begin
      tick();
      push("invalid_code", (k >= 5) ? 1 : 0);
      check({31'd0, no_feedback});
    end

    // Hall edge on the timeout cycle wins and restarts the timer.
    motor_en = 1'b0;
    tick();
    tick();
    hall = 3'b001;
    repeat (5) tick();
    motor_en = 1'b1;
    for (int k = 1; k <= 202; k++) begin
      tick();
      if (k == 97) hall = 3'b011;
      if (k == 102) begin push("edge_vs_timeout", 0);   check({31'd0, no_feedback}); end
      if (k == 201) begin push("restart_before", 0);    check({31'd0, no_feedback}); end
      if (k == 202) begin push("restart_timeout", 1);   check({31'd0, no_feedback}); end
    end

    // Both faults active, then reset mid-release.
    send(900,  0, "pre_trip", 0);
    send(1001, 0, "both_1", 0);
    send(1001, 0, "both_2", 0);
    send(1001, 0, "both_3", 0);
    send(1001, 1, "both_4", 0);
    send(900,  1, "mid_rel_1", 0);
    send(900,  1, "mid_rel_2", 0);
    push("both_no_feedback", 1); check({31'd0, no_feedback});
    hall = 3'b111;
    rst  = 1'b1;
    tick();
    push("rst2_overload", 0);    check({31'd0, current_overload});
    push("rst2_no_feedback", 0); check({31'd0, no_feedback});
    push("rst2_hall_edge", 0);   check({31'd0, hall_edge});
    push("rst2_ovl_cnt", 0);     check(32'(dut.ovl_cnt));
    push("rst2_fb_tmr", 0);      check(32'(dut.fb_tmr));
    rst      = 1'b0;
    motor_en = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      push("fill_no_edge", 0);
      check({31'd0, hall_edge});
    end

    // Reset in the middle of an over-limit run discards the partial count.
    send(1001, 0, "abort_1", 0);
    send(1001, 0, "abort_2", 0);
    send(1001, 0, "abort_3", 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send(1001, 0, "abort_after", 0);

    // Reset in the middle of a timeout clears the timer.
    hall     = 3'b101;
    motor_en = 1'b1;
    repeat (60) tick();
    rst = 1'b1;
    tick();
    push("abort_fb_tmr", 0);      check(32'(dut.fb_tmr));
    push("abort_no_feedback", 0); check({31'd0, no_feedback});
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
